// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: branch checkpoint queue plus predictor-table update sequencer.
// Optional feature macro BPQ_TAG_CHECK_EN: validate res_tag against head and report bad resolutions on tag_err.
module bp_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int GHR_W = 6,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [31:0]      alloc_pc,
  input  logic [GHR_W-1:0] alloc_ghr,
  input  logic             alloc_gpred,
  input  logic             alloc_lpred,
  input  logic             alloc_choose,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic [GHR_W-1:0] upd_ghr,
  output logic             upd_taken,
  output logic             upd_gcorr,
  output logic             upd_lcorr,
  output logic             mispredict,
  output logic [GHR_W-1:0] restore_ghr,
  output logic [TAG_W:0]   count,
  output logic             tag_err,
  output logic             dbgState
);

  // Handshakes: an allocation transfers on a rising edge where alloc_valid and
  // alloc_ready are both high, and alloc_ready never looks at alloc_valid.
  // Resolutions have no ready: one is taken only in IDLE with a non-empty queue.
  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);

  state_t           state;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic [31:0]      pcMem  [DEPTH];
  logic [GHR_W-1:0] ghrMem [DEPTH];
  logic [DEPTH-1:0] gMem;
  logic [DEPTH-1:0] lMem;
  logic [DEPTH-1:0] cMem;

  logic             allocFire;
  logic             resSeen;
  logic             tagOk;
  logic             resFire;
  logic             finalPred;
  logic             mispFire;
  logic [GHR_W-1:0] headGhr;

  assign alloc_ready = (count < FULL) && (state == IDLE);
  assign alloc_tag   = tail;
  assign dbgState    = (state == RECOVER);

  assign allocFire = alloc_valid & alloc_ready;
  assign resSeen   = res_valid & (state == IDLE);

`ifdef BPQ_TAG_CHECK_EN
  assign tagOk = (res_tag == head);
`else
  logic unusedTag;
  assign tagOk     = 1'b1;
  assign unusedTag = ^res_tag;
`endif

  assign resFire   = resSeen & (count != '0) & tagOk;
  assign headGhr   = ghrMem[head];
  assign finalPred = cMem[head] ? lMem[head] : gMem[head];
  assign mispFire  = resFire & (finalPred != res_taken);

  // Checkpoint payload is never reset; head/tail/count define which slots are live.
  always_ff @(posedge clk) begin
    if (allocFire) begin
      pcMem[tail]  <= alloc_pc;
      ghrMem[tail] <= alloc_ghr;
      gMem[tail]   <= alloc_gpred;
      lMem[tail]   <= alloc_lpred;
      cMem[tail]   <= alloc_choose;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_ghr     <= '0;
      upd_taken   <= 1'b0;
      upd_gcorr   <= 1'b0;
      upd_lcorr   <= 1'b0;
      mispredict  <= 1'b0;
      restore_ghr <= '0;
    end else begin
      upd_valid  <= resFire;
      mispredict <= mispFire;
      if (resFire) begin
        upd_pc      <= pcMem[head];
        upd_ghr     <= headGhr;
        upd_taken   <= res_taken;
        upd_gcorr   <= (gMem[head] == res_taken);
        upd_lcorr   <= (lMem[head] == res_taken);
        restore_ghr <= {headGhr[GHR_W-2:0], res_taken};
        head        <= head + 1'b1;
      end
      // A mispredict squashes every younger entry, including one allocated this edge.
      if (mispFire) begin
        state <= RECOVER;
        tail  <= head + 1'b1;
        count <= '0;
      end else begin
        state <= IDLE;
        if (allocFire) begin
          tail <= tail + 1'b1;
        end
        count <= count + {{TAG_W{1'b0}}, allocFire} - {{TAG_W{1'b0}}, resFire};
      end
    end
  end

`ifdef BPQ_TAG_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_err <= 1'b0;
    end else if (resSeen && !resFire) begin
      tag_err <= 1'b1;
    end
  end
`else
  assign tag_err = 1'b0;
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= FULL);
  a_recover_gap: assert property (@(posedge clk) disable iff (!rst) mispredict |=> !mispredict);

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed vector table, hand sequences and a random run against a queue model.
module tb_bp_update_ctrl;
  localparam int DEPTH = 4;
  localparam int GHR_W = 6;
  localparam int TAG_W = 2;
`ifdef BPQ_TAG_CHECK_EN
  localparam bit TAG_CHECK = 1'b1;
`else
  localparam bit TAG_CHECK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             alloc_valid;
  logic             alloc_ready;
  logic [31:0]      alloc_pc;
  logic [GHR_W-1:0] alloc_ghr;
  logic             alloc_gpred;
  logic             alloc_lpred;
  logic             alloc_choose;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_gcorr;
  logic             upd_lcorr;
  logic             mispredict;
  logic [GHR_W-1:0] restore_ghr;
  logic [TAG_W:0]   count;
  logic             tag_err;
  logic             dbg_state;

  bp_update_ctrl #(.DEPTH(DEPTH), .GHR_W(GHR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_ghr(alloc_ghr), .alloc_gpred(alloc_gpred), .alloc_lpred(alloc_lpred),
    .alloc_choose(alloc_choose), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_gcorr(upd_gcorr), .upd_lcorr(upd_lcorr), .mispredict(mispredict),
    .restore_ghr(restore_ghr), .count(count), .tag_err(tag_err), .dbgState(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard / reference model: in-flight branches as a plain queue
  logic [40:0] exp_q[$];
  int          m_head;
  int          m_tail;
  bit          m_recover;
  bit          m_err;
  logic        m_uv, m_tk, m_gc, m_lc, m_mis;
  logic [31:0] m_pc;
  logic [5:0]  m_ghr, m_rg;

  task automatic model_reset();
    exp_q.delete();
    m_head = 0; m_tail = 0; m_recover = 0; m_err = 0;
    m_uv = 0; m_tk = 0; m_gc = 0; m_lc = 0; m_mis = 0;
    m_pc = '0; m_ghr = '0; m_rg = '0;
  endtask

  task automatic model_edge();
    logic [40:0] e;
    bit ready, seen, ok, pred;
    ready = (exp_q.size() < DEPTH) && !m_recover;
    seen  = res_valid && !m_recover;
    ok    = seen && (exp_q.size() > 0) && (!TAG_CHECK || (int'(res_tag) == m_head));
    if (TAG_CHECK && seen && !ok) m_err = 1;
    m_uv  = ok;
    m_mis = 0;
    if (ok) begin
      e     = exp_q.pop_front();
      pred  = e[0] ? e[1] : e[2];
      m_pc  = e[40:9];
      m_ghr = e[8:3];
      m_tk  = res_taken;
      m_gc  = (e[2] == res_taken);
      m_lc  = (e[1] == res_taken);
      m_rg  = {e[7:3], res_taken};
      m_mis = (pred != res_taken);
      m_head = (m_head + 1) % DEPTH;
    end
    if (m_mis) begin
      exp_q.delete();
      m_tail    = m_head;
      m_recover = 1;
    end else begin
      m_recover = 0;
      if (alloc_valid && ready) begin
        exp_q.push_back({alloc_pc, alloc_ghr, alloc_gpred, alloc_lpred, alloc_choose});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    alloc_valid = 0; alloc_pc = '0; alloc_ghr = '0;
    alloc_gpred = 0; alloc_lpred = 0; alloc_choose = 0;
    res_valid = 0; res_tag = '0; res_taken = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    drive_idle();
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_upd_valid"}, 32'(upd_valid), 32'd0);
    check({p, "_upd_pc"}, upd_pc, 32'd0);
    check({p, "_upd_ghr"}, 32'(upd_ghr), 32'd0);
    check({p, "_upd_taken"}, 32'(upd_taken), 32'd0);
    check({p, "_upd_gcorr"}, 32'(upd_gcorr), 32'd0);
    check({p, "_upd_lcorr"}, 32'(upd_lcorr), 32'd0);
    check({p, "_mispredict"}, 32'(mispredict), 32'd0);
    check({p, "_restore_ghr"}, 32'(restore_ghr), 32'd0);
    check({p, "_count"}, 32'(count), 32'd0);
    check({p, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
    check({p, "_alloc_tag"}, 32'(alloc_tag), 32'd0);
    check({p, "_tag_err"}, 32'(tag_err), 32'd0);
    check({p, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // directed vector table: inputs for one edge, outputs expected just after it
  typedef struct {
    logic        av;  logic [31:0] pc; logic [5:0] ghr; logic g, l, c;
    logic        rv;  logic [1:0]  rt; logic tk;
    logic        e_uv; logic [31:0] e_pc; logic [5:0] e_ghr;
    logic        e_tk, e_gc, e_lc, e_mis; logic [5:0] e_rg;
    logic [2:0]  e_cnt; logic e_rdy; logic [1:0] e_tag;
  } vec_t;

  vec_t vecs[32];
  int   nvec = 0;

  task automatic add_vec(input int av, pc, ghr, g, l, c, rv, rt, tk,
                         uv, epc, eghr, etk, egc, elc, emis, erg, ecnt, erdy, etag);
    vec_t v;
    v.av = 1'(av); v.pc = 32'(pc); v.ghr = 6'(ghr); v.g = 1'(g); v.l = 1'(l); v.c = 1'(c);
    v.rv = 1'(rv); v.rt = 2'(rt); v.tk = 1'(tk);
    v.e_uv = 1'(uv); v.e_pc = 32'(epc); v.e_ghr = 6'(eghr); v.e_tk = 1'(etk);
    v.e_gc = 1'(egc); v.e_lc = 1'(elc); v.e_mis = 1'(emis); v.e_rg = 6'(erg);
    v.e_cnt = 3'(ecnt); v.e_rdy = 1'(erdy); v.e_tag = 2'(etag);
    vecs[nvec] = v;
    nvec++;
  endtask

  task automatic apply_vec(input int i);
    vec_t  v;
    string p;
    v = vecs[i];
    p = $sformatf("v%0d", i);
    @(negedge clk);
    alloc_valid = v.av; alloc_pc = v.pc; alloc_ghr = v.ghr;
    alloc_gpred = v.g; alloc_lpred = v.l; alloc_choose = v.c;
    res_valid = v.rv; res_tag = v.rt; res_taken = v.tk;
    @(posedge clk);
    #1;
    check({p, "_upd_valid"}, 32'(upd_valid), 32'(v.e_uv));
    check({p, "_upd_pc"}, upd_pc, v.e_pc);
    check({p, "_upd_ghr"}, 32'(upd_ghr), 32'(v.e_ghr));
    check({p, "_upd_taken"}, 32'(upd_taken), 32'(v.e_tk));
    check({p, "_upd_gcorr"}, 32'(upd_gcorr), 32'(v.e_gc));
    check({p, "_upd_lcorr"}, 32'(upd_lcorr), 32'(v.e_lc));
    check({p, "_mispredict"}, 32'(mispredict), 32'(v.e_mis));
    check({p, "_restore_ghr"}, 32'(restore_ghr), 32'(v.e_rg));
    check({p, "_count"}, 32'(count), 32'(v.e_cnt));
    check({p, "_alloc_ready"}, 32'(alloc_ready), 32'(v.e_rdy));
    check({p, "_alloc_tag"}, 32'(alloc_tag), 32'(v.e_tag));
  endtask

  task automatic rand_step();
    @(negedge clk);
    alloc_valid  = ($urandom_range(0, 99) < 60);
    alloc_pc     = $urandom;
    alloc_ghr    = 6'($urandom_range(0, 63));
    alloc_gpred  = 1'($urandom_range(0, 1));
    alloc_lpred  = 1'($urandom_range(0, 1));
    alloc_choose = 1'($urandom_range(0, 1));
    res_valid    = ($urandom_range(0, 99) < 45);
    res_tag      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_head);
    res_taken    = 1'($urandom_range(0, 1));
    #1;
    check("rnd_alloc_ready", 32'(alloc_ready), 32'((exp_q.size() < DEPTH) && !m_recover));
    check("rnd_alloc_tag", 32'(alloc_tag), 32'(m_tail));
    model_edge();
    @(posedge clk);
    #1;
    check("rnd_upd_valid", 32'(upd_valid), 32'(m_uv));
    check("rnd_upd_pc", upd_pc, m_pc);
    check("rnd_upd_ghr", 32'(upd_ghr), 32'(m_ghr));
    check("rnd_upd_taken", 32'(upd_taken), 32'(m_tk));
    check("rnd_upd_gcorr", 32'(upd_gcorr), 32'(m_gc));
    check("rnd_upd_lcorr", 32'(upd_lcorr), 32'(m_lc));
    check("rnd_mispredict", 32'(mispredict), 32'(m_mis));
    check("rnd_restore_ghr", 32'(restore_ghr), 32'(m_rg));
    check("rnd_count", 32'(count), 32'(exp_q.size()));
    check("rnd_tag_err", 32'(tag_err), 32'(m_err));
    check("rnd_state", 32'(dbg_state), 32'(m_recover));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   av pc     ghr  g l c  rv rt tk  uv upd_pc ghr  tk gc lc mis rg    cnt rdy tag
    add_vec(1, 'h100, 'h15, 1, 0, 0, 0, 0, 0, 0, 'h000, 'h00, 0, 0, 0, 0, 'h00, 1, 1, 1);
    add_vec(0, 'h000, 'h00, 0, 0, 0, 1, 0, 1, 1, 'h100, 'h15, 1, 1, 0, 0, 'h2B, 0, 1, 1);
    add_vec(0, 'h000, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h100, 'h15, 1, 1, 0, 0, 'h2B, 0, 1, 1);
    add_vec(1, 'h100, 'h15, 1, 0, 0, 0, 0, 0, 0, 'h100, 'h15, 1, 1, 0, 0, 'h2B, 1, 1, 2);
    add_vec(0, 'h000, 'h00, 0, 0, 0, 1, 1, 0, 1, 'h100, 'h15, 0, 0, 1, 1, 'h2A, 0, 0, 2);
    add_vec(1, 'h999, 'h3F, 0, 0, 0, 0, 0, 0, 0, 'h100, 'h15, 0, 0, 1, 0, 'h2A, 0, 1, 2);
    add_vec(1, 'h200, 'h01, 1, 0, 0, 0, 0, 0, 0, 'h100, 'h15, 0, 0, 1, 0, 'h2A, 1, 1, 3);
    add_vec(1, 'h204, 'h02, 1, 0, 0, 0, 0, 0, 0, 'h100, 'h15, 0, 0, 1, 0, 'h2A, 2, 1, 0);
    add_vec(1, 'h208, 'h04, 1, 1, 1, 0, 0, 0, 0, 'h100, 'h15, 0, 0, 1, 0, 'h2A, 3, 1, 1);
    add_vec(1, 'h20C, 'h08, 1, 0, 0, 0, 0, 0, 0, 'h100, 'h15, 0, 0, 1, 0, 'h2A, 4, 0, 2);
    add_vec(1, 'h600, 'h3F, 0, 0, 0, 1, 2, 1, 1, 'h200, 'h01, 1, 1, 0, 0, 'h03, 3, 1, 2);
    add_vec(1, 'h300, 'h3F, 0, 1, 1, 0, 0, 0, 0, 'h200, 'h01, 1, 1, 0, 0, 'h03, 4, 0, 3);
    add_vec(0, 'h000, 'h00, 0, 0, 0, 1, 3, 1, 1, 'h204, 'h02, 1, 1, 0, 0, 'h05, 3, 1, 3);
    add_vec(1, 'h400, 'h11, 0, 0, 0, 1, 0, 0, 1, 'h208, 'h04, 0, 0, 0, 1, 'h08, 0, 0, 1);
    add_vec(0, 'h000, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h208, 'h04, 0, 0, 0, 0, 'h08, 0, 1, 1);
    add_vec(1, 'h500, 'h2A, 0, 0, 0, 0, 0, 0, 0, 'h208, 'h04, 0, 0, 0, 0, 'h08, 1, 1, 2);
    add_vec(0, 'h000, 'h00, 0, 0, 0, 1, 1, 1, 1, 'h500, 'h2A, 1, 0, 0, 1, 'h15, 0, 0, 2);
    add_vec(1, 'h700, 'h00, 0, 0, 0, 1, 2, 0, 0, 'h500, 'h2A, 1, 0, 0, 0, 'h15, 0, 1, 2);

    drive_idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1;
    model_reset();

    for (int i = 0; i < nvec; i++) apply_vec(i);

    // resolution carrying a tag that is not the head
    do_reset();
    alloc_valid = 1; alloc_pc = 32'h100; alloc_ghr = 6'h15; alloc_gpred = 1;
    @(negedge clk);
    drive_idle();
    res_valid = 1; res_tag = 2'd2; res_taken = 1;
    @(posedge clk);
    #1;
`ifdef BPQ_TAG_CHECK_EN
    check("tag_bad_upd_valid", 32'(upd_valid), 32'd0);
    check("tag_bad_count", 32'(count), 32'd1);
    check("tag_bad_err", 32'(tag_err), 32'd1);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("tag_err_sticky", 32'(tag_err), 32'd1);
    check("tag_bad_count_hold", 32'(count), 32'd1);
`else
    check("tag_ign_upd_valid", 32'(upd_valid), 32'd1);
    check("tag_ign_upd_pc", upd_pc, 32'h100);
    check("tag_ign_count", 32'(count), 32'd0);
    check("tag_ign_err", 32'(tag_err), 32'd0);
`endif

    // asynchronous reset while the update and mispredict pulses are live
    do_reset();
    alloc_valid = 1; alloc_pc = 32'h100; alloc_ghr = 6'h15; alloc_gpred = 1;
    @(negedge clk);
    drive_idle();
    res_valid = 1; res_tag = 2'd0; res_taken = 0;
    @(posedge clk);
    #1;
    check("arst_pre_upd_valid", 32'(upd_valid), 32'd1);
    check("arst_pre_mispredict", 32'(mispredict), 32'd1);
    check("arst_pre_restore_ghr", 32'(restore_ghr), 32'h2A);
    #1;
    rst = 0;
    drive_idle();
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    rst = 1;
    model_reset();

    do_reset();
    for (int n = 0; n < 1500; n++) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Branch checkpoint queue and update sequencer for the tournament branch predictor. Each branch that leaves decode with a prediction is allocated an entry holding its PC, global-history snapshot and the three component predictions. When the branch resolves in M, the block issues one registered update to the predictor tables, detects a misprediction, supplies the repaired GHR and squashes every younger in-flight entry.

## Interface
- `DEPTH`, 4: queue entries; power of 2, ≥2.
- `GHR_W`, 6: global history width.
- `TAG_W`, 2: tag width, equal to log2(`DEPTH`).

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `alloc_valid` in 1: decoded branch requests an entry.
- `alloc_ready` out 1: entry can be accepted this cycle.
- `alloc_pc` in 32: branch PC.
- `alloc_ghr` in GHR_W: GHR value used to index the global PHT.
- `alloc_gpred` in 1: global prediction.
- `alloc_lpred` in 1: local prediction.
- `alloc_choose` in 1: chooser select; 0 = global, 1 = local.
- `alloc_tag` out TAG_W: tag given to an accepted branch (current tail pointer).
- `res_valid` in 1: branch resolved in M.
- `res_tag` in TAG_W: tag of the resolving branch.
- `res_taken` in 1: actual outcome.
- `upd_valid` out 1: one-cycle table-update strobe.
- `upd_pc` out 32: PC of the resolved branch.
- `upd_ghr` out GHR_W: the stored snapshot, used as the PHT index.
- `upd_taken` out 1: actual outcome.
- `upd_gcorr` out 1: global prediction was correct.
- `upd_lcorr` out 1: local prediction was correct.
- `mispredict` out 1: one-cycle strobe for redirect and GHR repair.
- `restore_ghr` out GHR_W: repaired history, {snapshot[GHR_W-2:0], res_taken}.
- `count` out TAG_W+1: number of occupied entries.
- `tag_err` out 1: sticky error flag for a bad resolution.

## Operation
- Storage is a circular buffer with `head`, `tail` and `count`.
- Allocation is accepted when `alloc_valid & alloc_ready`. The entry is written at `tail`, then `tail` and `count` are incremented.
- `alloc_ready` = (`count` < DEPTH) & ~`recover`. There is no full-queue bypass: a simultaneous resolve does not free a slot in the same cycle.
- Branches resolve in order, and only the head entry can resolve. A resolution is accepted when `res_valid` is high and `count` ≠ 0. It pops the head.
- On an accepted resolution, final prediction = `alloc_choose` ? `lpred` : `gpred`, taken from the head entry. A mispredict occurs when final prediction ≠ `res_taken`.
- On a mispredict:
  - Set `tail` = `head`+1 and `count` = 0, which squashes all younger entries.
  - Drop any allocation accepted on the same edge; it is on the wrong path.
  - Set `recover` for the next cycle.
- FSM states:
  - IDLE: normal operation.
  - RECOVER: one cycle, `alloc_ready` = 0, then unconditionally back to IDLE.
  - IDLE → RECOVER on a mispredicting resolution.
  - A `res_valid` seen while in RECOVER is ignored.
- `res_valid` with `count` = 0 is ignored and produces no update.
- Reset values: `head` = `tail` = `count` = 0; state IDLE; all `upd_*`, `mispredict`, `restore_ghr` and `tag_err` = 0; `alloc_ready` = 1.
- Entry contents are not reset.
- Pointers wrap modulo DEPTH.

## Timing
- Resolution sampled at edge N:
  - `upd_valid`, `upd_*`, `mispredict` and `restore_ghr` are registered and valid throughout cycle N+1.
  - `upd_valid` and `mispredict` are single-cycle pulses.
  - `restore_ghr` and the `upd_*` data fields hold their last value otherwise.
- Alloc-to-earliest-resolve latency: an entry allocated at edge N can resolve at edge N+1.
- `alloc_tag` and `alloc_ready` are combinational from state only, with no path from `alloc_valid`.
- Back-to-back resolutions are allowed every cycle, except during RECOVER.
- An asynchronous reset mid-operation clears all state immediately. In-flight pulses are cancelled.

## Configuration
- `BPQ_TAG_CHECK_EN` defined:
  - `res_tag` is compared with `head`.
  - On a mismatch, or on `res_valid` with an empty queue, the resolution is dropped: no pop, no update, no mispredict. `tag_err` is set and stays set until reset.
- `BPQ_TAG_CHECK_EN` undefined:
  - `res_tag` is ignored and any valid resolution pops the head.
  - `tag_err` is tied to 0.

## Test plan
- Reset, then allocate PC=0x100, ghr=6'h15, g=1, l=0, choose=0. Resolve taken → cycle+1: `upd_valid`=1, `upd_ghr`=6'h15, `gcorr`=1, `lcorr`=0, `mispredict`=0, `count`=0.
- Same entry resolved not-taken → `mispredict`=1, `restore_ghr`=6'h2A, `alloc_ready`=0 for exactly one cycle.
- Fill 4 entries → `alloc_ready`=0. Resolve the head while `alloc_valid`=1 → no allocation that cycle; `count`=3, then the next allocation succeeds with `alloc_tag`=0 (wrap).
- Queue of 3 entries; mispredict on the head with a simultaneous allocation → `count`=0, the new branch is dropped, the next allocation gets `alloc_tag` = old head+1.
- With `BPQ_TAG_CHECK_EN`: `res_tag`=2 while `head`=0 → no `upd_valid`, `tag_err`=1 sticky, `count` unchanged. Without the macro: the head pops.
- Assert `rst`=0 during the `upd_valid` cycle → all outputs return to their reset values asynchronously.
